// File: rtl/imm_pkg.sv
`default_nettype none
// imm_pkg -- format codes and opcode constants shared by the immediate generator.
// Rev 1.0
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_BAD  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// imm_decode -- combinational RV32I/RV64I immediate decode to an XLEN-wide value.
// Rev 1.0
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       is_shift;

  assign opc      = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Size casts of signed operands sign-extend; unsigned shamt operands zero-extend.
  always_comb begin
    imm = '0;
    fmt = FMT_BAD;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(inst[31:20]));
      end
      OPC_OP_IMM: begin
        if (!is_shift) begin
          fmt = FMT_I;
          imm = XLEN'($signed(inst[31:20]));
        end else if (XLEN == 64) begin
          fmt = FMT_SH;
          imm = XLEN'(inst[25:20]);
        end else if (!inst[25]) begin
          fmt = FMT_SH;
          imm = XLEN'(inst[24:20]);
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          if (!is_shift) begin
            fmt = FMT_I;
            imm = XLEN'($signed(inst[31:20]));
          end else if (!inst[25]) begin
            fmt = FMT_SH;
            imm = XLEN'(inst[24:20]);
          end
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_OP: fmt = FMT_NONE;
      OPC_OP32: begin
        if (XLEN == 64) fmt = FMT_NONE;
      end
      default: ;
    endcase
  end

  assign illegal = (fmt == FMT_BAD);

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// imm_gen_pipe -- registered immediate generator behind a 2-entry skid buffer.
// Rev 1.0
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  output logic [TAG_W-1:0] out_tag
);

  // Entry lives here rather than in the package because its widths follow XLEN/TAG_W.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, inst: '0, tag: '0};

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          in_entry;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, inst: in_inst, tag: in_tag};

  assign in_ready = !skid_valid && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  // Skid can only fill while main is held, so main is never empty with skid full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= in_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_inst    = main_q.inst;
  assign out_tag     = main_q.tag;

endmodule
`default_nettype wire
